// File: rtl/alu_arbiter_if.sv
// ----------------------------------------------------------------------------
// alu_arbiter_if
// Bundles the two requester channels, the two response channels, the
// requester-0 flush and the shared-ALU side of the arbiter.
//   slave  : the arbiter's view (takes requests, drives the ALU, returns data)
//   master : the environment's view (requesters and the shared ALU)
// Signals:
//   reqN_valid/ready, reqN_in1/in2/pc/op   request channel of requester N
//   rspN_valid/ready, rspN_data/branch     response channel of requester N
//   flush0                                 cancel requester-0 work in flight
//   alu_in1/alu_in2/pc_in/alu_instruction  operands driven to the shared ALU
//   alu_out/branch_taken                   combinational ALU result
// DATA_WIDTH must match the arbiter's DATA_WIDTH.
// ----------------------------------------------------------------------------
interface alu_arbiter_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  req0_valid, req1_valid;
  logic                  req0_ready, req1_ready;
  logic [DATA_WIDTH-1:0] req0_in1, req0_in2, req0_pc;
  logic [DATA_WIDTH-1:0] req1_in1, req1_in2, req1_pc;
  logic [4:0]            req0_op, req1_op;

  logic                  rsp0_valid, rsp1_valid;
  logic                  rsp0_ready, rsp1_ready;
  logic [DATA_WIDTH-1:0] rsp0_data, rsp1_data;
  logic                  rsp0_branch, rsp1_branch;

  logic                  flush0;

  logic [DATA_WIDTH-1:0] alu_in1, alu_in2, pc_in;
  logic [4:0]            alu_instruction;
  logic [DATA_WIDTH-1:0] alu_out;
  logic                  branch_taken;

  modport slave (
    input  req0_valid, req1_valid, req0_in1, req0_in2, req0_pc, req0_op,
           req1_in1, req1_in2, req1_pc, req1_op, rsp0_ready, rsp1_ready,
           flush0, alu_out, branch_taken,
    output req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_data,
           rsp1_data, rsp0_branch, rsp1_branch, alu_in1, alu_in2, pc_in,
           alu_instruction
  );

  modport master (
    output req0_valid, req1_valid, req0_in1, req0_in2, req0_pc, req0_op,
           req1_in1, req1_in2, req1_pc, req1_op, rsp0_ready, rsp1_ready,
           flush0, alu_out, branch_taken,
    input  req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_data,
           rsp1_data, rsp0_branch, rsp1_branch, alu_in1, alu_in2, pc_in,
           alu_instruction
  );
endinterface

// File: rtl/alu_arbiter.sv
// ----------------------------------------------------------------------------
// alu_arbiter
// Shares one combinational ALU between two requesters, one transaction at a
// time: IDLE (grant + operand latch) -> EXEC (ALU driven, result captured)
// -> RESP (result held until consumed). Round-robin between requesters;
// requester 0 may be flushed while its transaction is in EXEC or RESP.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    alu_arbiter_if.slave (request/response channels, flush, ALU side)
// Parameters:
//   DATA_WIDTH  operand/result width
//   ALU_NOP     opcode presented to the ALU outside EXEC
// ----------------------------------------------------------------------------
module alu_arbiter #(
  parameter int         DATA_WIDTH = 32,
  parameter logic [4:0] ALU_NOP    = 5'b00000
) (
  input  logic           clk,
  input  logic           rst_n,
  alu_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t                state_q, state_d;
  logic                  grant_q, grant_d;   // requester owning the slot
  logic                  ptr_q, ptr_d;       // preferred requester on contention
  logic                  sel;
  logic                  latch, capture;
  logic                  ready0, ready1;
  logic                  flush_hit;

  logic [DATA_WIDTH-1:0] in1_q, in2_q, pc_q, res_q;
  logic [4:0]            op_q;
  logic                  br_q;

  // Lone requester wins regardless of pointer; on contention the pointer decides.
  assign sel       = (bus.req0_valid && bus.req1_valid) ? ptr_q : bus.req1_valid;
  assign flush_hit = bus.flush0 && !grant_q;

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    latch   = 1'b0;
    capture = 1'b0;
    ready0  = 1'b0;
    ready1  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req0_valid || bus.req1_valid) begin
          latch   = 1'b1;
          ready0  = !sel;
          ready1  = sel;
          grant_d = sel;
          ptr_d   = !sel;
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (flush_hit) begin
          ptr_d   = 1'b1;
          state_d = IDLE;
        end else begin
          capture = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        // Flush wins over a simultaneous response consume.
        if (flush_hit) begin
          ptr_d   = 1'b1;
          state_d = IDLE;
        end else if (grant_q ? bus.rsp1_ready : bus.rsp0_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  // NOTE: operand and result registers are plain flops (no memory array), so
  // they are all cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= 1'b0;
      ptr_q   <= 1'b0;
      in1_q   <= '0;
      in2_q   <= '0;
      pc_q    <= '0;
      op_q    <= ALU_NOP;
      res_q   <= '0;
      br_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      if (latch) begin
        in1_q <= sel ? bus.req1_in1 : bus.req0_in1;
        in2_q <= sel ? bus.req1_in2 : bus.req0_in2;
        pc_q  <= sel ? bus.req1_pc  : bus.req0_pc;
        op_q  <= sel ? bus.req1_op  : bus.req0_op;
      end
      if (capture) begin
        res_q <= bus.alu_out;
        br_q  <= bus.branch_taken;
      end
    end
  end

  // Ready is gated by rst_n so an asserted reset silences it immediately.
  assign bus.req0_ready      = ready0 && rst_n;
  assign bus.req1_ready      = ready1 && rst_n;

  assign bus.alu_in1         = in1_q;
  assign bus.alu_in2         = in2_q;
  assign bus.pc_in           = pc_q;
  assign bus.alu_instruction = (state_q == EXEC) ? op_q : ALU_NOP;

  assign bus.rsp0_valid      = (state_q == RESP) && !grant_q;
  assign bus.rsp1_valid      = (state_q == RESP) &&  grant_q;
  assign bus.rsp0_data       = bus.rsp0_valid ? res_q : '0;
  assign bus.rsp1_data       = bus.rsp1_valid ? res_q : '0;
  assign bus.rsp0_branch     = bus.rsp0_valid && br_q;
  assign bus.rsp1_branch     = bus.rsp1_valid && br_q;

endmodule
